// File: rtl/rcc_lse_seq_if.sv
// Handshake/configuration/status bundle between an RCC controller and the LSE sequencer.
// master drives requests, configuration and analog status; slave (the sequencer) drives controls.
interface rcc_lse_seq_if #(
  parameter int TO_W = 16
);
  logic            start;
  logic            stop;
  logic            cfg_byp;
  logic [1:0]      cfg_drv;
  logic            cfg_css_en;
  logic [1:0]      cfg_rtcsel;
  logic [TO_W-1:0] cfg_timeout;
  logic            lserdy;
  logic            lsecss_fail;

  logic            lseon;
  logic            lsebyp;
  logic            lsecsson;
  logic [1:0]      lsedrv;
  logic            rtcsel_wr;
  logic [1:0]      rtcsel;
  logic            busy;
  logic            running;
  logic            err_to;
  logic            err_css;
  logic [2:0]      state;

  modport master (
    output start, stop, cfg_byp, cfg_drv, cfg_css_en, cfg_rtcsel, cfg_timeout,
           lserdy, lsecss_fail,
    input  lseon, lsebyp, lsecsson, lsedrv, rtcsel_wr, rtcsel, busy, running,
           err_to, err_css, state
  );

  modport slave (
    input  start, stop, cfg_byp, cfg_drv, cfg_css_en, cfg_rtcsel, cfg_timeout,
           lserdy, lsecss_fail,
    output lseon, lsebyp, lsecsson, lsedrv, rtcsel_wr, rtcsel, busy, running,
           err_to, err_css, state
  );
endinterface

// File: rtl/rcc_lse_seq.sv
// LSE oscillator start/stability/CSS/RTC-select sequencer; every output comes straight from a flop.
// Optional macro RCC_LSE_SEQ_DRV_RAMP_EN: full drive strength until the crystal is stable.
module rcc_lse_seq #(
  parameter int STABLE_CNT = 8,
  parameter int TO_W       = 16
) (
  input logic         clk,
  input logic         rst,
  rcc_lse_seq_if.slave lse
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    WAIT_RDY = 3'd2,
    STABLE   = 3'd3,
    CSS_ARM  = 3'd4,
    RUN      = 3'd5,
    FAIL     = 3'd6,
    STOPPING = 3'd7
  } state_e;

  localparam logic [7:0]      STABLE_LAST = 8'(STABLE_CNT - 1);
  localparam logic [TO_W-1:0] TO_ONE      = TO_W'(1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] toCnt_q, toCnt_d;
  logic [7:0]      stableCnt_q, stableCnt_d;
  logic            byp_q, byp_d;
  logic [1:0]      drv_q, drv_d;
  logic            cssEn_q, cssEn_d;
  logic [1:0]      rtcselCfg_q, rtcselCfg_d;
  logic            rtcselDone_q, rtcselDone_d;

  logic            lseon_q, lseon_d;
  logic            lsebyp_q, lsebyp_d;
  logic            lsecsson_q, lsecsson_d;
  logic [1:0]      lsedrv_q, lsedrv_d;
  logic            rtcselWr_q, rtcselWr_d;
  logic [1:0]      rtcsel_q, rtcsel_d;
  logic            busy_q, busy_d;
  logic            running_q, running_d;
  logic            errTo_q, errTo_d;
  logic            errCss_q, errCss_d;

  logic            startAcc;
  logic            cssTrip;

  // Next state, sampled configuration and next output values (outputs follow state_d).
  always_comb begin
    state_d      = state_q;
    toCnt_d      = toCnt_q;
    stableCnt_d  = stableCnt_q;
    byp_d        = byp_q;
    drv_d        = drv_q;
    cssEn_d      = cssEn_q;
    rtcselCfg_d  = rtcselCfg_q;
    rtcselDone_d = rtcselDone_q;
    lsecsson_d   = lsecsson_q;
    rtcselWr_d   = 1'b0;
    rtcsel_d     = rtcsel_q;
    errTo_d      = errTo_q;
    errCss_d     = errCss_q;

    startAcc = lse.start && (((state_q == IDLE) && !lse.stop) || (state_q == FAIL));
    cssTrip  = lsecsson_q && lse.lsecss_fail;

    // A zero timeout never reaches 1, so it never expires.
    if (((state_q == WAIT_RDY) || (state_q == STABLE)) && (toCnt_q > TO_ONE))
      toCnt_d = toCnt_q - TO_ONE;

    if (startAcc) begin
      state_d      = START;
      byp_d        = lse.cfg_byp;
      drv_d        = lse.cfg_drv;
      cssEn_d      = lse.cfg_css_en;
      rtcselCfg_d  = lse.cfg_rtcsel;
      toCnt_d      = lse.cfg_timeout;
      stableCnt_d  = 8'd0;
      rtcselDone_d = 1'b0;
      errTo_d      = 1'b0;
      errCss_d     = 1'b0;
    end else begin
      case (state_q)
        START: begin
          state_d = lse.stop ? STOPPING : WAIT_RDY;
        end
        WAIT_RDY: begin
          if (lse.stop) begin
            state_d = STOPPING;
          end else if (lse.lserdy) begin
            state_d     = STABLE;
            stableCnt_d = 8'd0;
          end else if (toCnt_q == TO_ONE) begin
            state_d = FAIL;
            errTo_d = 1'b1;
          end
        end
        STABLE: begin
          if (lse.stop) begin
            state_d = STOPPING;
          end else if (lse.lserdy) begin
            if (stableCnt_q == STABLE_LAST) begin
              stableCnt_d = 8'd0;
              state_d     = cssEn_q ? CSS_ARM : RUN;
              lsecsson_d  = cssEn_q;
            end else begin
              stableCnt_d = stableCnt_q + 8'd1;
            end
          end else begin
            stableCnt_d = 8'd0;
            if (toCnt_q == TO_ONE) begin
              state_d = FAIL;
              errTo_d = 1'b1;
            end
          end
        end
        CSS_ARM: begin
          state_d = RUN;
        end
        RUN: begin
          if (lse.stop && !lsecsson_q)
            state_d = STOPPING;
        end
        STOPPING: begin
          if (!lse.lserdy)
            state_d = IDLE;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    // A clock-security failure overrides everything else in the same cycle.
    if (cssTrip) begin
      state_d    = FAIL;
      lsecsson_d = 1'b0;
      errCss_d   = 1'b1;
    end

    if ((state_d == RUN) && !rtcselDone_q && (rtcselCfg_q != 2'b00)) begin
      rtcselWr_d   = 1'b1;
      rtcsel_d     = rtcselCfg_q;
      rtcselDone_d = 1'b1;
    end

    lseon_d   = state_d inside {START, WAIT_RDY, STABLE, CSS_ARM, RUN};
    lsebyp_d  = (state_d inside {START, WAIT_RDY, STABLE, CSS_ARM, RUN, STOPPING}) ? byp_d : 1'b0;
    busy_d    = !(state_d inside {IDLE, RUN, FAIL});
    running_d = (state_d == RUN);

`ifdef RCC_LSE_SEQ_DRV_RAMP_EN
    // An external clock has no crystal to kick, so bypass skips the boost.
    if ((state_d inside {START, WAIT_RDY, STABLE}) && !byp_d)
      lsedrv_d = 2'b11;
    else
      lsedrv_d = drv_d;
`else
    lsedrv_d = drv_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      toCnt_q      <= '0;
      stableCnt_q  <= 8'd0;
      byp_q        <= 1'b0;
      drv_q        <= 2'b00;
      cssEn_q      <= 1'b0;
      rtcselCfg_q  <= 2'b00;
      rtcselDone_q <= 1'b0;
      lseon_q      <= 1'b0;
      lsebyp_q     <= 1'b0;
      lsecsson_q   <= 1'b0;
      lsedrv_q     <= 2'b00;
      rtcselWr_q   <= 1'b0;
      rtcsel_q     <= 2'b00;
      busy_q       <= 1'b0;
      running_q    <= 1'b0;
      errTo_q      <= 1'b0;
      errCss_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      toCnt_q      <= toCnt_d;
      stableCnt_q  <= stableCnt_d;
      byp_q        <= byp_d;
      drv_q        <= drv_d;
      cssEn_q      <= cssEn_d;
      rtcselCfg_q  <= rtcselCfg_d;
      rtcselDone_q <= rtcselDone_d;
      lseon_q      <= lseon_d;
      lsebyp_q     <= lsebyp_d;
      lsecsson_q   <= lsecsson_d;
      lsedrv_q     <= lsedrv_d;
      rtcselWr_q   <= rtcselWr_d;
      rtcsel_q     <= rtcsel_d;
      busy_q       <= busy_d;
      running_q    <= running_d;
      errTo_q      <= errTo_d;
      errCss_q     <= errCss_d;
    end
  end

  assign lse.lseon     = lseon_q;
  assign lse.lsebyp    = lsebyp_q;
  assign lse.lsecsson  = lsecsson_q;
  assign lse.lsedrv    = lsedrv_q;
  assign lse.rtcsel_wr = rtcselWr_q;
  assign lse.rtcsel    = rtcsel_q;
  assign lse.busy      = busy_q;
  assign lse.running   = running_q;
  assign lse.err_to    = errTo_q;
  assign lse.err_css   = errCss_q;
  assign lse.state     = state_q;

endmodule

// File: tb/tb_rcc_lse_seq.sv
// Directed bench for rcc_lse_seq: startup, timeout, stability glitch, CSS, abort and reset cases.
module tb_rcc_lse_seq;

`ifdef RCC_LSE_SEQ_DRV_RAMP_EN
  localparam logic [1:0] DRV_EARLY = 2'b11;
`else
  localparam logic [1:0] DRV_EARLY = 2'b01;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   pulseCnt = 0;

  rcc_lse_seq_if #(.TO_W(16)) lseIf ();

  rcc_lse_seq #(.STABLE_CNT(8), .TO_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .lse (lseIf.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (lseIf.rtcsel_wr) pulseCnt++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Loads configuration and pulses start; returns just after the edge that enters START.
  task automatic applyStimulus(input logic byp, input logic [1:0] drv, input logic cssEn,
                               input logic [1:0] rtcsel, input logic [15:0] timeout);
    lseIf.cfg_byp     = byp;
    lseIf.cfg_drv     = drv;
    lseIf.cfg_css_en  = cssEn;
    lseIf.cfg_rtcsel  = rtcsel;
    lseIf.cfg_timeout = timeout;
    lseIf.start       = 1'b1;
    step(1);
    lseIf.start       = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst               = 1'b1;
    lseIf.start       = 1'b0;
    lseIf.stop        = 1'b0;
    lseIf.cfg_byp     = 1'b0;
    lseIf.cfg_drv     = 2'b00;
    lseIf.cfg_css_en  = 1'b0;
    lseIf.cfg_rtcsel  = 2'b00;
    lseIf.cfg_timeout = 16'd0;
    lseIf.lserdy      = 1'b0;
    lseIf.lsecss_fail = 1'b0;
    step(2);
    checkOutput("rst_state", 32'(lseIf.state), 32'd0);
    checkOutput("rst_lseon", 32'(lseIf.lseon), 32'd0);
    checkOutput("rst_busy", 32'(lseIf.busy), 32'd0);
    checkOutput("rst_lsedrv", 32'(lseIf.lsedrv), 32'd0);
    checkOutput("rst_errs", 32'({lseIf.err_to, lseIf.err_css}), 32'd0);
    rst = 1'b0;
    step(1);

    // Normal start, ready arrives a few cycles into WAIT_RDY, no CSS.
    applyStimulus(1'b0, 2'b01, 1'b0, 2'b01, 16'd100);
    checkOutput("a_start_state", 32'(lseIf.state), 32'd1);
    checkOutput("a_start_lseon", 32'(lseIf.lseon), 32'd1);
    checkOutput("a_start_busy", 32'(lseIf.busy), 32'd1);
    checkOutput("a_start_drv", 32'(lseIf.lsedrv), 32'(DRV_EARLY));
    step(1);
    checkOutput("a_wait_state", 32'(lseIf.state), 32'd2);
    step(7);
    checkOutput("a_wait_hold", 32'(lseIf.state), 32'd2);
    lseIf.lserdy = 1'b1;
    step(1);
    checkOutput("a_stable_state", 32'(lseIf.state), 32'd3);
    checkOutput("a_stable_drv", 32'(lseIf.lsedrv), 32'(DRV_EARLY));
    step(7);
    checkOutput("a_stable7_state", 32'(lseIf.state), 32'd3);
    checkOutput("a_stable7_run", 32'(lseIf.running), 32'd0);
    step(1);
    checkOutput("a_run_state", 32'(lseIf.state), 32'd5);
    checkOutput("a_run_running", 32'(lseIf.running), 32'd1);
    checkOutput("a_run_wr", 32'(lseIf.rtcsel_wr), 32'd1);
    checkOutput("a_run_rtcsel", 32'(lseIf.rtcsel), 32'd1);
    checkOutput("a_run_busy", 32'(lseIf.busy), 32'd0);
    checkOutput("a_run_drv", 32'(lseIf.lsedrv), 32'd1);
    step(1);
    checkOutput("a_run_wr_off", 32'(lseIf.rtcsel_wr), 32'd0);
    lseIf.stop = 1'b1;
    step(1);
    lseIf.stop = 1'b0;
    checkOutput("a_stopping", 32'(lseIf.state), 32'd7);
    checkOutput("a_stopping_lseon", 32'(lseIf.lseon), 32'd0);
    step(1);
    checkOutput("a_stopping_hold", 32'(lseIf.state), 32'd7);
    lseIf.lserdy = 1'b0;
    step(1);
    checkOutput("a_idle", 32'(lseIf.state), 32'd0);
    checkOutput("a_idle_byp", 32'(lseIf.lsebyp), 32'd0);

    // Ready glitches low at stable count 5; eight fresh high cycles are required.
    applyStimulus(1'b0, 2'b01, 1'b0, 2'b00, 16'd0);
    step(1);
    lseIf.lserdy = 1'b1;
    step(1);
    checkOutput("b_stable", 32'(lseIf.state), 32'd3);
    step(5);
    lseIf.lserdy = 1'b0;
    step(1);
    checkOutput("b_glitch_state", 32'(lseIf.state), 32'd3);
    lseIf.lserdy = 1'b1;
    step(7);
    checkOutput("b_seven_state", 32'(lseIf.state), 32'd3);
    checkOutput("b_seven_run", 32'(lseIf.running), 32'd0);
    step(1);
    checkOutput("b_run", 32'(lseIf.running), 32'd1);
    checkOutput("b_no_pulse", 32'(pulseCnt), 32'd1);
    lseIf.stop   = 1'b1;
    lseIf.lserdy = 1'b0;
    step(1);
    lseIf.stop = 1'b0;
    checkOutput("b_stopping", 32'(lseIf.state), 32'd7);
    step(1);
    checkOutput("b_idle", 32'(lseIf.state), 32'd0);

    // Timeout of 20 with ready held low.
    applyStimulus(1'b0, 2'b01, 1'b0, 2'b00, 16'd20);
    step(1);
    checkOutput("c_wait", 32'(lseIf.state), 32'd2);
    step(19);
    checkOutput("c_wait19", 32'(lseIf.state), 32'd2);
    checkOutput("c_no_err_yet", 32'(lseIf.err_to), 32'd0);
    step(1);
    checkOutput("c_fail", 32'(lseIf.state), 32'd6);
    checkOutput("c_err_to", 32'(lseIf.err_to), 32'd1);
    checkOutput("c_lseon", 32'(lseIf.lseon), 32'd0);
    checkOutput("c_busy", 32'(lseIf.busy), 32'd0);

    // Restart from FAIL with CSS armed; stop is ignored, then CSS failure.
    applyStimulus(1'b0, 2'b01, 1'b1, 2'b10, 16'd0);
    checkOutput("d_start", 32'(lseIf.state), 32'd1);
    checkOutput("d_err_clr", 32'(lseIf.err_to), 32'd0);
    step(1);
    lseIf.lserdy = 1'b1;
    step(1);
    checkOutput("d_stable", 32'(lseIf.state), 32'd3);
    step(7);
    checkOutput("d_stable7", 32'(lseIf.state), 32'd3);
    step(1);
    checkOutput("d_css_arm", 32'(lseIf.state), 32'd4);
    checkOutput("d_csson", 32'(lseIf.lsecsson), 32'd1);
    step(1);
    checkOutput("d_run", 32'(lseIf.state), 32'd5);
    checkOutput("d_run_wr", 32'(lseIf.rtcsel_wr), 32'd1);
    checkOutput("d_run_rtcsel", 32'(lseIf.rtcsel), 32'd2);
    lseIf.stop = 1'b1;
    step(1);
    lseIf.stop = 1'b0;
    checkOutput("d_stop_ignored", 32'(lseIf.state), 32'd5);
    checkOutput("d_csson_hold", 32'(lseIf.lsecsson), 32'd1);
    lseIf.lsecss_fail = 1'b1;
    step(1);
    lseIf.lsecss_fail = 1'b0;
    checkOutput("d_fail", 32'(lseIf.state), 32'd6);
    checkOutput("d_err_css", 32'(lseIf.err_css), 32'd1);
    checkOutput("d_csson_off", 32'(lseIf.lsecsson), 32'd0);
    checkOutput("d_lseon_off", 32'(lseIf.lseon), 32'd0);
    checkOutput("d_pulses", 32'(pulseCnt), 32'd2);

    // Reset clears flags; start+stop in IDLE; reset during WAIT_RDY in bypass.
    rst          = 1'b1;
    lseIf.lserdy = 1'b0;
    step(1);
    rst = 1'b0;
    checkOutput("e_rst_err_css", 32'(lseIf.err_css), 32'd0);
    checkOutput("e_rst_state", 32'(lseIf.state), 32'd0);
    lseIf.start = 1'b1;
    lseIf.stop  = 1'b1;
    step(1);
    lseIf.start = 1'b0;
    lseIf.stop  = 1'b0;
    checkOutput("e_startstop", 32'(lseIf.state), 32'd0);
    checkOutput("e_startstop_busy", 32'(lseIf.busy), 32'd0);
    applyStimulus(1'b1, 2'b01, 1'b0, 2'b01, 16'd0);
    checkOutput("e_byp", 32'(lseIf.lsebyp), 32'd1);
    checkOutput("e_byp_drv", 32'(lseIf.lsedrv), 32'd1);
    step(1);
    checkOutput("e_wait", 32'(lseIf.state), 32'd2);
    rst = 1'b1;
    step(1);
    checkOutput("e_mid_rst_state", 32'(lseIf.state), 32'd0);
    checkOutput("e_mid_rst_outs",
                32'({lseIf.lseon, lseIf.lsebyp, lseIf.lsecsson, lseIf.lsedrv, lseIf.busy}), 32'd0);
    rst = 1'b0;
    step(3);
    checkOutput("e_no_pulse", 32'(pulseCnt), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rcc_lse_seq.md
RCC_LSE_SEQ -- requirements
Module: rcc_lse_seq

Interface
REQ-001 Parameter STABLE_CNT, default 8: number of consecutive lserdy-high cycles required before the oscillator counts as stable (range 1..255).
REQ-002 Parameter TO_W, default 16: width of the startup timeout counter.
REQ-003 clk  input  1  the single clock for the block; every flop SHALL be clocked by it.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  single-cycle request to start the LSE.
REQ-006 stop  input  1  single-cycle request to stop the LSE.
REQ-007 cfg_byp  input  1  bypass mode (external clock); SHALL be sampled on an accepted start.
REQ-008 cfg_drv  input  2  run-time drive level; SHALL be sampled on an accepted start.
REQ-009 cfg_css_en  input  1  arms the clock-security system (CSS) after the oscillator is stable.
REQ-010 cfg_rtcsel  input  2  RTC clock source to program once RUN is reached; 2'b00 means no programming.
REQ-011 cfg_timeout  input  TO_W  startup timeout in cycles; 0 means no timeout.
REQ-012 lserdy  input  1  oscillator-ready indication from the analog block.
REQ-013 lsecss_fail  input  1  CSS failure indication.
REQ-014 lseon, lsebyp, lsecsson  output  1 each  oscillator control outputs.
REQ-015 lsedrv  output  2  oscillator drive-level control.
REQ-016 rtcsel_wr  output  1  single-cycle write strobe for the RTC source select.
REQ-017 rtcsel  output  2  RTC source value accompanying rtcsel_wr.
REQ-018 busy  output  1  high in every state except IDLE, RUN and FAIL.
REQ-019 running  output  1  high only in RUN.
REQ-020 err_to, err_css  output  1 each  sticky timeout and CSS-failure flags.
REQ-021 state  output  3  current FSM state encoding: IDLE=0, START=1, WAIT_RDY=2, STABLE=3, CSS_ARM=4, RUN=5, FAIL=6, STOPPING=7.

Function
REQ-022 start SHALL be accepted only in IDLE or FAIL; an accepted start SHALL sample cfg_*, clear err_to and err_css, and move the FSM to START.
REQ-023 If start and stop arrive in the same cycle in IDLE, stop SHALL win and the FSM SHALL stay in IDLE; start in any other state SHALL be ignored.
REQ-024 START SHALL last exactly 1 cycle: lseon=1 and lsebyp=sampled cfg_byp, then move to WAIT_RDY with the timeout counter loaded.
REQ-025 In WAIT_RDY the timeout counter SHALL decrement each cycle; when it reaches 1 with lserdy low, the FSM SHALL go to FAIL and set err_to (a timeout of N therefore fails after N WAIT_RDY cycles).
REQ-026 In WAIT_RDY, lserdy=1 SHALL move the FSM to STABLE, and the timeout SHALL keep running in STABLE.
REQ-027 In STABLE, the stable counter SHALL increment while lserdy=1 and clear to 0 when lserdy drops; reaching STABLE_CNT SHALL exit to CSS_ARM if cfg_css_en is set, otherwise to RUN.
REQ-028 CSS_ARM SHALL last 1 cycle and set lsecsson=1; lsecsson SHALL then hold until lsecss_fail or rst.
REQ-029 On the first cycle in RUN with cfg_rtcsel != 0, rtcsel_wr SHALL pulse for 1 cycle with rtcsel=cfg_rtcsel; the pulse SHALL occur once per start.
REQ-030 In RUN, stop SHALL be ignored while lsecsson=1; otherwise stop SHALL move the FSM to STOPPING.
REQ-031 STOPPING SHALL drive lseon=0 and wait for lserdy=0, then return to IDLE with lsebyp=0.
REQ-032 stop in START, WAIT_RDY or STABLE SHALL abort to STOPPING without setting an error flag.
REQ-033 lsecss_fail while lsecsson=1 SHALL, in the same cycle from any state, force the next state to FAIL, clear lseon and lsecsson, and set err_css; it SHALL take priority over stop and the timeout.
REQ-034 In FAIL, lseon, lsecsson and lsebyp SHALL be 0 and the error flags SHALL hold until an accepted start or rst.
REQ-035 All outputs SHALL be registered.

Reset
REQ-036 While rst=1, at each clk edge: state=IDLE, all outputs 0, counters 0, sampled configuration 0.
REQ-037 rst asserted mid-sequence SHALL abandon the sequence without issuing an rtcsel_wr pulse.

Configuration
REQ-038 With RCC_LSE_SEQ_DRV_RAMP_EN defined, lsedrv SHALL be 2'b11 from START through STABLE and switch to the sampled cfg_drv on entry to CSS_ARM or RUN; in bypass mode, lsedrv SHALL equal cfg_drv throughout.
REQ-039 With RCC_LSE_SEQ_DRV_RAMP_EN undefined, lsedrv SHALL equal the sampled cfg_drv from START onward, and the ramp logic SHALL be absent.

Verification
REQ-040 start with cfg_timeout=100 and cfg_css_en=0, lserdy rising at cycle 10 -> running high after STABLE_CNT (8) stable cycles; rtcsel_wr pulses once with cfg_rtcsel=2'b01.
REQ-041 start with cfg_timeout=20 and lserdy held low -> FAIL after 20 WAIT_RDY cycles, err_to=1, lseon=0.
REQ-042 lserdy glitching low at stable count 5 -> stable counter restarts at 0; running asserts only after 8 consecutive high cycles.
REQ-043 cfg_css_en=1 in RUN, then stop -> stop ignored; then lsecss_fail -> FAIL next cycle, err_css=1, lsecsson=0.
REQ-044 start and stop in the same cycle in IDLE -> stays in IDLE; rst in WAIT_RDY -> all outputs 0 next cycle, no rtcsel_wr.
REQ-045 With RCC_LSE_SEQ_DRV_RAMP_EN and cfg_drv=2'b01 -> lsedrv=2'b11 until stable, then 2'b01; with the macro undefined -> lsedrv=2'b01 throughout.
